// File: rtl/aict_irq_ctrl_if.sv
// Strobe/ack register bus between the AICT address decoder (master) and a device slot (slave).
// Signal names follow the slave's point of view.
interface aict_irq_ctrl_if #(
    parameter int unsigned MASK_LEN = 8
);
    logic                i_stb;
    logic                o_ack;
    logic [MASK_LEN-1:0] i_addr;
    logic                i_rw;
    logic [31:0]         i_dtw;
    logic [31:0]         o_dtr;

    modport master (
        output i_stb,
        output i_addr,
        output i_rw,
        output i_dtw,
        input  o_ack,
        input  o_dtr
    );

    modport slave (
        input  i_stb,
        input  i_addr,
        input  i_rw,
        input  i_dtw,
        output o_ack,
        output o_dtr
    );
endinterface

// File: rtl/aict_irq_ctrl.sv
// AICT interrupt vector table: per-line handler/enable entries, rising-edge pending capture,
// lowest-number priority select and a req/ack handshake towards the core.
module aict_irq_ctrl #(
    parameter int unsigned NIRQ     = 24,
    parameter int unsigned MASK_LEN = 8
) (
    input  logic               clk,
    input  logic               reset,
    aict_irq_ctrl_if.slave     bus,
    input  logic [NIRQ-1:0]    i_irq,
    output logic               o_irq,
    output logic [31:0]        o_vec,
    output logic [4:0]         o_nirq,
    input  logic               i_irq_ack
);

    localparam logic [31:0] PEND_WORD = 32'h0000_0020;
    localparam logic [31:0] STAT_WORD = 32'h0000_0021;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_ack;
    logic [31:0]     r_dtr;
    logic [29:0]     r_hnd [NIRQ];
    logic [NIRQ-1:0] r_en;
    logic [NIRQ-1:0] r_pend;
    logic [NIRQ-1:0] r_irq_q;
    logic            r_irq;
    logic [29:0]     r_vec;
    logic [4:0]      r_nirq;

    logic            w_acc;
    logic            w_wr;
    logic [31:0]     w_word;
    logic            w_unused;
    logic [NIRQ-1:0] w_set;
    logic [NIRQ-1:0] w_sw_clr;
    logic [NIRQ-1:0] w_ack_clr;
    logic [NIRQ-1:0] w_pend_nxt;
    logic [NIRQ-1:0] w_cand;
    logic            w_sel_vld;
    logic [4:0]      w_sel;
    logic [29:0]     w_sel_hnd;
    logic [31:0]     w_rdata;
    logic            w_irq_nxt;
    logic [29:0]     w_vec_nxt;
    logic [4:0]      w_nirq_nxt;

    // A strobe is only taken in a cycle without ack, so each transfer costs two cycles.
    assign w_acc    = bus.i_stb & ~r_ack;
    assign w_wr     = w_acc & bus.i_rw;
    assign w_word   = 32'(bus.i_addr[MASK_LEN-1:2]);
    assign w_unused = ^bus.i_addr[1:0];

    assign w_set      = i_irq & ~r_irq_q & r_en;
    assign w_sw_clr   = (w_wr && (w_word == PEND_WORD)) ? bus.i_dtw[NIRQ-1:0] : '0;
    assign w_pend_nxt = (r_pend & ~(w_sw_clr | w_ack_clr)) | w_set;

    // Core ack retires the bit of the line currently being requested.
    always_comb begin
        w_ack_clr = '0;
        for (int i = 0; i < int'(NIRQ); i++) begin
            w_ack_clr[i] = (r_state == ST_REQ) && i_irq_ack && (r_nirq == 5'(i));
        end
    end

    // Lowest-numbered enabled pending line wins.
    assign w_cand    = r_pend & r_en;
    assign w_sel_vld = |w_cand;

    always_comb begin
        w_sel     = '0;
        w_sel_hnd = '0;
        for (int i = int'(NIRQ) - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_sel     = 5'(i);
                w_sel_hnd = r_hnd[i];
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < int'(NIRQ); i++) begin
            if (w_word == 32'(i + 1)) begin
                w_rdata = {r_hnd[i], 1'b0, r_en[i]};
            end
        end
        if (w_word == PEND_WORD) begin
            w_rdata = 32'(r_pend);
        end
        if (w_word == STAT_WORD) begin
            w_rdata = {23'd0, r_nirq, 3'd0, r_irq};
        end
    end

    // Bus response, entry table and pending/edge state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ack   <= 1'b0;
            r_dtr   <= '0;
            r_en    <= '0;
            r_pend  <= '0;
            r_irq_q <= '0;
            for (int i = 0; i < int'(NIRQ); i++) begin
                r_hnd[i] <= '0;
            end
        end else begin
            r_ack   <= w_acc;
            r_dtr   <= (w_acc && !bus.i_rw) ? w_rdata : '0;
            r_irq_q <= i_irq;
            r_pend  <= w_pend_nxt;
            for (int i = 0; i < int'(NIRQ); i++) begin
                if (w_wr && (w_word == 32'(i + 1))) begin
                    r_hnd[i] <= bus.i_dtw[31:2];
                    r_en[i]  <= bus.i_dtw[0];
                end
            end
        end
    end

    // FSM state and registered request outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_irq   <= 1'b0;
            r_vec   <= '0;
            r_nirq  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_irq   <= w_irq_nxt;
            r_vec   <= w_vec_nxt;
            r_nirq  <= w_nirq_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_sel_vld) w_state_nxt = ST_REQ;
            ST_REQ:  if (i_irq_ack) w_state_nxt = ST_GAP;
            ST_GAP:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Vector and line number are frozen for the whole REQ phase.
    always_comb begin
        w_irq_nxt  = r_irq;
        w_vec_nxt  = r_vec;
        w_nirq_nxt = r_nirq;
        case (r_state)
            ST_IDLE: begin
                if (w_sel_vld) begin
                    w_irq_nxt  = 1'b1;
                    w_vec_nxt  = w_sel_hnd;
                    w_nirq_nxt = w_sel;
                end
            end
            ST_REQ:  if (i_irq_ack) w_irq_nxt = 1'b0;
            ST_GAP:  w_irq_nxt = 1'b0;
            default: w_irq_nxt = 1'b0;
        endcase
    end

    assign bus.o_ack = r_ack;
    assign bus.o_dtr = r_dtr;
    assign o_irq     = r_irq;
    assign o_vec     = {r_vec, 2'b00};
    assign o_nirq    = r_nirq;

endmodule

// File: tb/tb_aict_irq_ctrl.sv
// Bench for aict_irq_ctrl: register table vectors, directed interrupt sequences and a
// randomized phase, all compared every cycle against a rule-level reference model.
module tb_aict_irq_ctrl;

    localparam int unsigned NIRQ = 24;
    localparam int unsigned ML   = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [NIRQ-1:0] irq;
    logic            irq_ack;
    logic            o_irq;
    logic [31:0]     o_vec;
    logic [4:0]      o_nirq;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    aict_irq_ctrl_if #(.MASK_LEN(ML)) bus ();

    aict_irq_ctrl #(.NIRQ(NIRQ), .MASK_LEN(ML)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .i_irq     (irq),
        .o_irq     (o_irq),
        .o_vec     (o_vec),
        .o_nirq    (o_nirq),
        .i_irq_ack (irq_ack)
    );

    // Reference model state
    logic [31:0]     m_hnd [NIRQ];
    logic [NIRQ-1:0] m_en;
    logic [NIRQ-1:0] m_pend;
    logic [NIRQ-1:0] m_irq_q;
    logic            m_ack;
    logic [31:0]     m_dtr;
    logic            m_irq;
    logic            m_gap;
    logic [31:0]     m_vec;
    logic [4:0]      m_nirq;

    typedef struct {
        bit          rw;
        logic [7:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [16];

    task automatic model_update();
        logic            acc;
        int              w;
        logic [31:0]     rd;
        logic [NIRQ-1:0] setm;
        logic [NIRQ-1:0] clrm;
        logic [NIRQ-1:0] pend_n;
        if (reset) begin
            for (int n = 0; n < int'(NIRQ); n++) m_hnd[n] = 32'd0;
            m_en = '0; m_pend = '0; m_irq_q = '0; m_ack = 1'b0; m_dtr = 32'd0;
            m_irq = 1'b0; m_gap = 1'b0; m_vec = 32'd0; m_nirq = 5'd0;
            return;
        end
        acc = bus.i_stb && !m_ack;
        w   = int'(bus.i_addr) / 4;
        rd  = 32'd0;
        if (w >= 1 && w <= int'(NIRQ)) rd = m_hnd[w-1] | 32'(m_en[w-1]);
        else if (w == 32) rd = 32'(m_pend);
        else if (w == 33) rd = (32'(m_nirq) << 4) | 32'(m_irq);
        setm = irq & ~m_irq_q & m_en;
        clrm = '0;
        if (acc && bus.i_rw && w == 32) clrm = bus.i_dtw[NIRQ-1:0];
        if (m_irq && irq_ack) clrm[m_nirq] = 1'b1;
        pend_n = (m_pend & ~clrm) | setm;
        if (m_irq) begin
            if (irq_ack) begin m_irq = 1'b0; m_gap = 1'b1; end
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else begin
            for (int n = 0; n < int'(NIRQ); n++) begin
                if (m_pend[n] && m_en[n]) begin
                    m_irq = 1'b1; m_vec = m_hnd[n]; m_nirq = 5'(n);
                    break;
                end
            end
        end
        m_pend = pend_n;
        if (acc && bus.i_rw && w >= 1 && w <= int'(NIRQ)) begin
            m_hnd[w-1] = bus.i_dtw & 32'hFFFF_FFFC;
            m_en[w-1]  = bus.i_dtw[0];
        end
        m_ack   = acc;
        m_dtr   = (acc && !bus.i_rw) ? rd : 32'd0;
        m_irq_q = irq;
    endtask

    task automatic compare_model();
        checks++;
        if (bus.o_ack !== m_ack || bus.o_dtr !== m_dtr || o_irq !== m_irq ||
            o_vec !== m_vec || o_nirq !== m_nirq) begin
            failures++;
            $display("FAIL model t=%0t act/exp ack=%b/%b dtr=%h/%h irq=%b/%b vec=%h/%h nirq=%0d/%0d",
                     $time, bus.o_ack, m_ack, bus.o_dtr, m_dtr, o_irq, m_irq,
                     o_vec, m_vec, o_nirq, m_nirq);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_model();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_op(input bit rw, input logic [7:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp, input string name);
        bus.i_stb = 1'b1; bus.i_rw = rw; bus.i_addr = addr; bus.i_dtw = wd;
        step();
        bus.i_stb = 1'b0;
        chk({name, "_ack"}, 32'(bus.o_ack), 32'd1);
        if (!rw) chk({name, "_rd"}, bus.o_dtr, exp);
        step();
        chk({name, "_ack_drop"}, 32'(bus.o_ack), 32'd0);
        chk({name, "_dtr_drop"}, bus.o_dtr, 32'd0);
    endtask

    task automatic wait_irq(input int budget, input string name);
        int n = 0;
        while (o_irq !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk(name, 32'(o_irq), 32'd1);
    endtask

    task automatic pulse(input int line);
        irq[line] = 1'b1;
        step();
        irq[line] = 1'b0;
    endtask

    task automatic ack_req();
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nreq;
        reset = 1'b1; irq = '0; irq_ack = 1'b0;
        bus.i_stb = 1'b0; bus.i_rw = 1'b0; bus.i_addr = '0; bus.i_dtw = '0;

        tbl[0]  = '{1'b0, 8'h04, 32'h0, 32'h0};
        tbl[1]  = '{1'b0, 8'h80, 32'h0, 32'h0};
        tbl[2]  = '{1'b0, 8'h84, 32'h0, 32'h0};
        tbl[3]  = '{1'b1, 8'h08, 32'hFFFF_FFFF, 32'h0};
        tbl[4]  = '{1'b0, 8'h08, 32'h0, 32'hFFFF_FFFD};
        tbl[5]  = '{1'b0, 8'h0A, 32'h0, 32'hFFFF_FFFD};
        tbl[6]  = '{1'b1, 8'h08, 32'h0, 32'h0};
        tbl[7]  = '{1'b0, 8'h08, 32'h0, 32'h0};
        tbl[8]  = '{1'b1, 8'h64, 32'hDEAD_BEEF, 32'h0};
        tbl[9]  = '{1'b0, 8'h64, 32'h0, 32'h0};
        tbl[10] = '{1'b0, 8'hF0, 32'h0, 32'h0};
        tbl[11] = '{1'b1, 8'h84, 32'hFFFF_FFFF, 32'h0};
        tbl[12] = '{1'b0, 8'h84, 32'h0, 32'h0};
        tbl[13] = '{1'b1, 8'h60, 32'h0000_6001, 32'h0};
        tbl[14] = '{1'b0, 8'h60, 32'h0, 32'h0000_6001};
        tbl[15] = '{1'b1, 8'h60, 32'h0, 32'h0};

        repeat (3) step();
        reset = 1'b0;
        step();
        chk("rst_irq", 32'(o_irq), 32'd0);
        chk("rst_vec", o_vec, 32'd0);
        chk("rst_nirq", 32'(o_nirq), 32'd0);
        chk("rst_ack", 32'(bus.o_ack), 32'd0);

        for (int i = 0; i < 16; i++) begin
            bus_op(tbl[i].rw, tbl[i].addr, tbl[i].wd, tbl[i].exp, $sformatf("tbl%0d", i));
        end

        // Single line request and ack
        bus_op(1'b1, 8'h04, 32'h0000_1001, 32'h0, "wr_e0");
        pulse(0);
        wait_irq(1, "irq0_up");
        chk("irq0_vec", o_vec, 32'h0000_1000);
        chk("irq0_nirq", 32'(o_nirq), 32'd0);
        ack_req();
        chk("irq0_down", 32'(o_irq), 32'd0);
        bus_op(1'b0, 8'h80, 32'h0, 32'h0, "pend_after0");

        // Two simultaneous rises, lower line first
        bus_op(1'b1, 8'h10, 32'h0000_3001, 32'h0, "wr_e3");
        bus_op(1'b1, 8'h18, 32'h0000_5001, 32'h0, "wr_e5");
        irq[3] = 1'b1; irq[5] = 1'b1;
        step();
        irq = '0;
        wait_irq(2, "prio_first");
        chk("prio_nirq3", 32'(o_nirq), 32'd3);
        chk("prio_vec3", o_vec, 32'h0000_3000);
        ack_req();
        chk("prio_gap", 32'(o_irq), 32'd0);
        wait_irq(3, "prio_second");
        chk("prio_nirq5", 32'(o_nirq), 32'd5);
        chk("prio_vec5", o_vec, 32'h0000_5000);
        ack_req();

        // Disabled line and held level
        pulse(7);
        repeat (4) step();
        chk("dis7_noirq", 32'(o_irq), 32'd0);
        bus_op(1'b0, 8'h80, 32'h0, 32'h0, "dis7_pend");
        bus_op(1'b1, 8'h0C, 32'h0000_2001, 32'h0, "wr_e2");
        irq[2] = 1'b1;
        nreq = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (o_irq) begin
                nreq++;
                ack_req();
            end
        end
        chk("level_once", 32'(nreq), 32'd1);
        irq[2] = 1'b0;

        // Entry rewrite and software clear while requesting
        bus_op(1'b1, 8'h14, 32'h0000_4001, 32'h0, "wr_e4");
        pulse(4);
        wait_irq(2, "irq4_up");
        chk("irq4_nirq", 32'(o_nirq), 32'd4);
        bus_op(1'b1, 8'h14, 32'h0, 32'h0, "clr_e4");
        bus_op(1'b1, 8'h80, 32'h0000_0010, 32'h0, "swclr4");
        chk("hold_irq", 32'(o_irq), 32'd1);
        chk("hold_vec", o_vec, 32'h0000_4000);
        chk("hold_nirq", 32'(o_nirq), 32'd4);
        bus_op(1'b0, 8'h84, 32'h0, 32'h0000_0041, "status_req4");
        ack_req();
        chk("irq4_down", 32'(o_irq), 32'd0);
        nreq = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (o_irq) nreq++;
        end
        chk("irq4_norearm", 32'(nreq), 32'd0);

        // New rise on the line being acked: set wins
        bus_op(1'b1, 8'h08, 32'h0000_1101, 32'h0, "wr_e1");
        pulse(1);
        wait_irq(2, "irq1_up");
        chk("irq1_nirq", 32'(o_nirq), 32'd1);
        bus_op(1'b0, 8'h80, 32'h0, 32'h0000_0002, "pend1_req");
        irq[1] = 1'b1; irq_ack = 1'b1;
        step();
        irq[1] = 1'b0; irq_ack = 1'b0;
        chk("rerise_gap", 32'(o_irq), 32'd0);
        wait_irq(3, "rerise_up");
        chk("rerise_nirq", 32'(o_nirq), 32'd1);
        chk("rerise_vec", o_vec, 32'h0000_1100);

        // Reset in the middle of a request
        reset = 1'b1;
        step();
        chk("midrst_irq", 32'(o_irq), 32'd0);
        chk("midrst_vec", o_vec, 32'd0);
        reset = 1'b0;
        step();
        bus_op(1'b0, 8'h08, 32'h0, 32'h0, "midrst_e1");
        bus_op(1'b0, 8'h80, 32'h0, 32'h0, "midrst_pend");

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if (!bus.i_stb || bus.o_ack) begin
                bus.i_stb  = ($urandom_range(0, 2) == 0);
                bus.i_rw   = ($urandom_range(0, 1) == 1);
                case ($urandom_range(0, 5))
                    0:       bus.i_addr = 8'h80;
                    1:       bus.i_addr = 8'h84;
                    2:       bus.i_addr = 8'hF0;
                    default: bus.i_addr = 8'(4 + 4 * $urandom_range(0, 25));
                endcase
                bus.i_addr = bus.i_addr | 8'($urandom_range(0, 3));
                bus.i_dtw  = $urandom;
            end
            irq     = irq ^ NIRQ'($urandom & $urandom & $urandom);
            irq_ack = ($urandom_range(0, 3) == 0);
            reset   = ($urandom_range(0, 599) == 0);
            step();
        end
        reset = 1'b0; bus.i_stb = 1'b0; irq_ack = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aict_irq_ctrl.md
Name: aict_irq_ctrl

Overview:
- Interrupt vector table device that sits directly downstream of the AICT address decoder, on one of its device slots.
- Holds one handler-address/enable entry per interrupt line and latches rising edges on the interrupt inputs as pending.
- Priority-selects the lowest-numbered enabled pending line and presents its vector to the core with a request/acknowledge handshake.
- Supervisor software programs it through the decoder's strobe/ack bus.

Parameters:
- NIRQ, 24, number of interrupt lines (1..30).
- MASK_LEN, 8, width of the device byte offset from the decoder.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- i_stb  input  1  bus strobe from decoder; held by master until o_ack.
- o_ack  output  1  bus acknowledge, one-cycle pulse.
- i_addr  input  MASK_LEN  byte offset within the AICT window.
- i_rw  input  1  1 = write, 0 = read.
- i_dtw  input  32  write data.
- o_dtr  output  32  read data, valid while o_ack=1.
- i_irq  input  NIRQ  raw interrupt lines, synchronous to clk.
- o_irq  output  1  interrupt request to core.
- o_vec  output  32  handler address of the requested line (low 2 bits 0).
- o_nirq  output  5  number of the requested line.
- i_irq_ack  input  1  core has taken the request.

Behaviour:
- Reset: all entries 0, pending 0, edge history 0, o_ack=0, o_dtr=0, o_irq=0, o_vec=0, o_nirq=0, FSM=IDLE.
- Register map, offsets word-aligned; i_addr[1:0] is ignored:
  - 0x00: reserved to the decoder, never strobed.
  - 0x04+4n, n<NIRQ: entry n. Bits [31:2] = handler address, bit0 = enable, bit1 reads 0.
  - 0x80: PENDING. Read returns pending bits. Write is 1-to-clear.
  - 0x84: STATUS. Bit0 = o_irq, bits[8:4] = o_nirq. Read-only.
  - Any other offset: reads 0, writes ignored, still acknowledged.
- Bus timing:
  - i_stb=1 with o_ack=0 in cycle N → o_ack=1 in cycle N+1.
  - Write commits at the clock edge ending cycle N.
  - Read data is registered and presented in N+1.
  - i_stb is ignored in any cycle where o_ack=1, so back-to-back transfers take 2 cycles each.
  - o_dtr returns to 0 when o_ack=0.
- Edge capture:
  - irq_q <= i_irq every cycle.
  - rise = i_irq & ~irq_q.
  - pending[n] sets on rise[n] only if entry n is enabled.
  - A level held high does not re-set pending.
- Pending clear sources: PENDING write-1, or i_irq_ack for the requested line.
  - Set and clear on the same bit in the same cycle: set wins.
- Priority: sel = lowest n with pending[n] & enable[n].
- FSM:
  - IDLE: any sel valid → REQ. Latch o_vec={entry[31:2],2'b0} and o_nirq=n; o_irq=1 from the next cycle.
  - REQ: o_irq, o_vec, o_nirq held stable, even if the entry is rewritten or disabled. On i_irq_ack: clear pending[o_nirq], o_irq=0, → GAP.
  - GAP: one cycle with o_irq=0 so the pending update is visible → IDLE.
- Software clear of the requested bit while in REQ: the request stays up until i_irq_ack. The ack then clears an already-clear bit, which is harmless.
- i_irq_ack outside REQ: ignored.
- Disabling an entry does not clear its pending bit; the bit is not selected while disabled and becomes selectable again when re-enabled.
- Reset mid-request: o_irq drops on the next edge and all state returns to reset values.

Test Plan:
- Reset, then read 0x04, 0x80, 0x84 → all 0. o_irq=0. o_ack pulses exactly 1 cycle after each i_stb.
- Write 0x04 ← 0x0000_1001 (entry 0, vec 0x1000, enabled). Pulse i_irq[0] for 1 cycle → o_irq=1 within 2 cycles, o_vec=0x1000, o_nirq=0. Assert i_irq_ack → o_irq=0, PENDING reads 0.
- Enable entries 3 (vec 0x3000) and 5 (vec 0x5000); raise i_irq[5] and i_irq[3] in the same cycle:
  - → first request o_nirq=3, o_vec=0x3000.
  - After ack and GAP → o_nirq=5, o_vec=0x5000.
- Entry 7 disabled, pulse i_irq[7] → PENDING bit7 stays 0, no o_irq. Hold i_irq[2] high with entry 2 enabled → exactly one request, no re-trigger after ack.
- While in REQ for line 4, write entry 4 ← 0 and write PENDING ← 0x10 → o_vec and o_nirq unchanged until i_irq_ack. Then o_irq=0 and no new request.
- Rise on i_irq[1] in the same cycle as the i_irq_ack clearing line 1 → pending[1] remains 1 and a new request for line 1 follows the GAP cycle. Read offset 0xF0 → 0 with ack. Assert reset during REQ → o_irq=0 next cycle.
